md_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer that reuses the CPU's existing 32-bit combinational ALU for all wide add/subtract work instead of instantiating its own adder. It sits beside the ALU in the execute stage. It accepts `multu`/`divu` requests from the controller and drives the ALU's `data1`/`data2`/`op` inputs for 32 iterations. It returns the 64-bit result in `hi`/`lo`, with `busy`/`done` handshaking toward the stall logic.

---
 rtl/md_sequencer.sv | 122 ++++++++++++
 tb/tb_md_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the shared 32-bit ALU.
// Each run is 32 iterations of shift-add (multu) or restoring subtract (divu).
module md_sequencer #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_ans
);

  // state | meaning
  // IDLE  | waiting for start, hi/lo hold last result
  // RUN   | iterating, ALU owned by the sequencer
  // DONE  | result valid, one-cycle done pulse; start accepted here too
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [31:0] opnd, opnd_nx;
  logic [31:0] hi_nx, lo_nx;
  logic        mode_q, mode_nx;
  logic [31:0] shl;
  logic        carry;
  logic        take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      opnd   <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      opnd   <= opnd_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
      mode_q <= mode_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Partial remainder shifted left; when hi[31] is set the true value exceeds 2^32,
  // so the subtract always succeeds and wraps back into range.
  assign shl   = {hi[30:0], lo[31]};
  assign carry = (alu_ans < hi);
  assign take  = hi[31] | (shl >= opnd);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    opnd_nx   = opnd;
    hi_nx     = hi;
    lo_nx     = lo;
    mode_nx   = mode_q;
    alu_data1 = 32'd0;
    alu_data2 = 32'd0;
    alu_op    = OP_ADD;

    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          mode_nx = mode;
          cnt_nx  = 5'd0;
          if (mode && (rt_val == 32'd0)) begin
            hi_nx    = rs_val;
            lo_nx    = 32'hFFFF_FFFF;
            state_nx = DONE;
          end else begin
            opnd_nx  = mode ? rt_val : rs_val;
            hi_nx    = 32'd0;
            lo_nx    = mode ? rs_val : rt_val;
            state_nx = RUN;
          end
        end
      end

      RUN: begin
        cnt_nx = cnt + 5'd1;
        if (mode_q) begin
          alu_data1 = shl;
          alu_data2 = opnd;
          alu_op    = OP_SUB;
          if (take) begin
            hi_nx = alu_ans;
            lo_nx = {lo[30:0], 1'b1};
          end else begin
            hi_nx = shl;
            lo_nx = {lo[30:0], 1'b0};
          end
        end else begin
          alu_data1 = hi;
          alu_data2 = opnd;
          alu_op    = OP_ADD;
          if (lo[0]) {hi_nx, lo_nx} = {carry, alu_ans, lo[31:1]};
          else       {hi_nx, lo_nx} = {1'b0, hi, lo[31:1]};
        end
        if (cnt == 5'd31) state_nx = DONE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer with a behavioural ALU and
// a plain-arithmetic reference for multu/divu results and handshake timing.
module tb_md_sequencer;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_data1, alu_data2;
  logic [2:0]  alu_op;
  logic [31:0] alu_ans;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_ans = (alu_op == ADD) ? alu_data1 + alu_data2 :
                   (alu_op == SUB) ? alu_data1 - alu_data2 : 32'hDEAD_BEEF;

  md_sequencer #(.OP_ADD(ADD), .OP_SUB(SUB)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_op(alu_op), .alu_ans(alu_ans)
  );

  function automatic logic [63:0] ref_result(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    if (!m) return wa * wb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one request from a point just after a rising edge and follows it to done.
  // inj > 0 pulses start with scrambled operands in that cycle of the run.
  task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b, input int inj,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int nbusy, output int done_at,
                        output logic [31:0] d1, output logic [31:0] d2, output logic [2:0] op1);
    rhi = 0; rlo = 0; nbusy = 0; done_at = 0; d1 = 0; d2 = 0; op1 = 0;
    mode = m; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin d1 = alu_data1; d2 = alu_data2; op1 = alu_op; end
      if (inj > 0 && k == inj) begin
        start = 1'b1; mode = ~m; rs_val = $urandom; rt_val = $urandom;
      end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin done_at = k; rhi = hi; rlo = lo; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    checks++;
    if (alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || alu_op !== ADD) begin
      errors++;
      $display("FAIL reset_alu: d1=%h d2=%h op=%b, required 0 0 %b", alu_data1, alu_data2, alu_op, ADD);
    end
    reset = 1'b1;
    idle(2);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic        tm[8];
    logic [31:0] ta[8], tb[8];
    logic [31:0] rhi, rlo, d1, d2;
    logic [2:0]  op1;
    logic [63:0] exp;
    int          nb, da;
    tm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ta = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0001_0000, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_1234, 32'h0000_0005};
    tb = '{32'hFFFF_FFFF, 32'd0, 32'h0001_0000, 32'd7, 32'd1, 32'd3, 32'd0, 32'hF000_0001};
    for (int i = 0; i < 8; i++) begin
      idle(2);
      run_op(tm[i], ta[i], tb[i], 0, rhi, rlo, nb, da, d1, d2, op1);
      exp = ref_result(tm[i], ta[i], tb[i]);
      checks++;
      if ({rhi, rlo} !== exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h, required hi=%h lo=%h", i, rhi, rlo, exp[63:32], exp[31:0]);
      end
      checks++;
      if (nb !== ((tm[i] && tb[i] == 0) ? 0 : 32) || da !== ((tm[i] && tb[i] == 0) ? 1 : 33)) begin
        errors++;
        $display("FAIL directed_timing[%0d]: busy_cycles=%0d done_at=%0d, required %0d %0d", i, nb, da,
                 (tm[i] && tb[i] == 0) ? 0 : 32, (tm[i] && tb[i] == 0) ? 1 : 33);
      end
      if (!(tm[i] && tb[i] == 0)) begin
        checks++;
        if (!tm[i] && (d1 !== 32'd0 || d2 !== ta[i] || op1 !== ADD)) begin
          errors++;
          $display("FAIL directed_alu_mul[%0d]: d1=%h d2=%h op=%b, required 0 %h %b", i, d1, d2, op1, ta[i], ADD);
        end else if (tm[i] && (d1 !== {31'd0, ta[i][31]} || d2 !== tb[i] || op1 !== SUB)) begin
          errors++;
          $display("FAIL directed_alu_div[%0d]: d1=%h d2=%h op=%b, required %h %h %b", i, d1, d2, op1,
                   {31'd0, ta[i][31]}, tb[i], SUB);
        end
      end
    end
    idle(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'h0000_0000 || hi !== 32'h0000_0005) begin
      errors++;
      $display("FAIL hold_after_done: done=%b busy=%b hi=%h lo=%h, required 0 0 00000005 00000000", done, busy, hi, lo);
    end
  endtask

  task automatic test_random;
    logic        m;
    logic [31:0] a, b, rhi, rlo, d1, d2;
    logic [2:0]  op1;
    logic [63:0] exp;
    int          nb, da, sel;
    for (int i = 0; i < 40; i++) begin
      m   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 4);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      idle($urandom_range(0, 2));
      run_op(m, a, b, 0, rhi, rlo, nb, da, d1, d2, op1);
      exp = ref_result(m, a, b);
      checks++;
      if ({rhi, rlo} !== exp || da !== ((m && b == 0) ? 1 : 33)) begin
        errors++;
        $display("FAIL random[%0d] m=%b a=%h b=%h: hi=%h lo=%h done_at=%0d, required hi=%h lo=%h done_at=%0d",
                 i, m, a, b, rhi, rlo, da, exp[63:32], exp[31:0], (m && b == 0) ? 1 : 33);
      end
    end
  endtask

  task automatic test_start_during_run;
    logic [31:0] rhi, rlo, d1, d2;
    logic [2:0]  op1;
    int          nb, da;
    idle(2);
    run_op(1'b1, 32'd1000, 32'd33, 10, rhi, rlo, nb, da, d1, d2, op1);
    checks++;
    if (rlo !== 32'd30 || rhi !== 32'd10 || nb !== 32 || da !== 33) begin
      errors++;
      $display("FAIL start_in_run: hi=%0d lo=%0d busy_cycles=%0d done_at=%0d, required 10 30 32 33", rhi, rlo, nb, da);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rhi, rlo, d1, d2;
    logic [2:0]  op1;
    logic [63:0] exp;
    int          nb, da;
    idle(2);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1001, 0, rhi, rlo, nb, da, d1, d2, op1);
    exp = ref_result(1'b0, 32'hDEAD_BEEF, 32'h0000_1001);
    checks++;
    if ({rhi, rlo} !== exp || da !== 33) begin
      errors++;
      $display("FAIL b2b_first: hi=%h lo=%h done_at=%0d, required %h %h 33", rhi, rlo, da, exp[63:32], exp[31:0]);
    end
    run_op(1'b1, 32'hCAFE_F00D, 32'h0000_0123, 0, rhi, rlo, nb, da, d1, d2, op1);
    exp = ref_result(1'b1, 32'hCAFE_F00D, 32'h0000_0123);
    checks++;
    if ({rhi, rlo} !== exp || nb !== 32 || da !== 33 || op1 !== SUB) begin
      errors++;
      $display("FAIL b2b_second: hi=%h lo=%h busy_cycles=%0d done_at=%0d op=%b, required %h %h 32 33 %b",
               rhi, rlo, nb, da, op1, exp[63:32], exp[31:0], SUB);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] rhi, rlo, d1, d2;
    logic [2:0]  op1;
    int          nb, da;
    int          saw_done;
    idle(2);
    mode = 1'b0; rs_val = 32'h0F0F_1234; rt_val = 32'hFFFF_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(19);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort: busy=%b, required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 ||
        alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || alu_op !== ADD) begin
      errors++;
      $display("FAIL async_abort: busy=%b done=%b hi=%h lo=%h d1=%h d2=%h op=%b, required all reset values",
               busy, done, hi, lo, alu_data1, alu_data2, alu_op);
    end
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done_cycles=%0d, required 0", saw_done);
    end
    run_op(1'b0, 32'd3, 32'd5, 0, rhi, rlo, nb, da, d1, d2, op1);
    checks++;
    if (rlo !== 32'd15 || rhi !== 32'd0 || da !== 33) begin
      errors++;
      $display("FAIL after_abort_mul: hi=%0d lo=%0d done_at=%0d, required 0 15 33", rhi, rlo, da);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_directed;
    test_random;
    test_start_during_run;
    test_back_to_back;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
